// File: rtl/sample_feeder_if.sv
// Load/serve bundle between a training-sample feeder and its consumer.
// The slave modport is the feeder side; master is the loader/consumer side.
interface sample_feeder_if #(
    parameter int EPOCH_W = 16
);
    logic               loadEn;
    logic signed [6:0]  loadX1;
    logic signed [6:0]  loadX2;
    logic signed [1:0]  loadT;
    logic               loadLast;
    logic               start;
    logic               requestFlag;
    logic               done;
    logic [31:0]        nOut;
    logic signed [6:0]  x1Out;
    logic signed [6:0]  x2Out;
    logic signed [1:0]  tOut;
    logic               dataReady;
    logic [EPOCH_W-1:0] epoch;
    logic               busy;
    logic               overflow;

    modport slave (
        input  loadEn, loadX1, loadX2, loadT, loadLast, start, requestFlag, done,
        output nOut, x1Out, x2Out, tOut, dataReady, epoch, busy, overflow
    );

    modport master (
        output loadEn, loadX1, loadX2, loadT, loadLast, start, requestFlag, done,
        input  nOut, x1Out, x2Out, tOut, dataReady, epoch, busy, overflow
    );
endinterface

// File: rtl/sample_feeder.sv
// Stores a training set of (x1, x2, t) samples and serves them one at a time
// to a consumer on request, counting completed passes over the set.
module sample_feeder #(
    parameter int DEPTH   = 512,
    parameter int EPOCH_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    sample_feeder_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SMP_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SERVE,
        FETCH,
        ISSUE,
        FINISH
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       ptr;
    logic [EPOCH_W-1:0]     epoch_q;
    logic                   overflow_q;
    logic                   busy_q;

    logic [SMP_W-1:0]       mem [DEPTH];
    logic [SMP_W-1:0]       rd_p0;
    logic signed [6:0]      x1_p1;
    logic signed [6:0]      x2_p1;
    logic signed [1:0]      t_p1;
    logic                   vld_p2;

    logic                   idle_like;
    logic                   full;
    logic                   last_ptr;
    logic                   wr_en;
    logic [PTR_W-1:0]       wr_addr;
    logic                   rd_en;

    function automatic logic [EPOCH_W-1:0] sat_inc(input logic [EPOCH_W-1:0] v);
        if (v == {EPOCH_W{1'b1}})
            return v;
        return v + 1'b1;
    endfunction

    assign idle_like = (state == IDLE) || (state == FINISH);
    assign full      = (count == CNT_W'(DEPTH));
    assign last_ptr  = (CNT_W'(ptr) == count - CNT_W'(1));

    // A fresh load always lands in entry 0; writes into a full set are dropped.
    assign wr_en   = rst && bus.loadEn && (idle_like || (state == LOAD && !full));
    assign wr_addr = idle_like ? '0 : count[PTR_W-1:0];
    assign rd_en   = (state == SERVE) && bus.requestFlag && !bus.done;

    // Sample storage: not reset, contents undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= {bus.loadX1, bus.loadX2, bus.loadT};
        if (rd_en)
            rd_p0 <= mem[ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            ptr        <= '0;
            epoch_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            vld_p2     <= 1'b0;
            x1_p1      <= '0;
            x2_p1      <= '0;
            t_p1       <= '0;
        end else begin
            vld_p2 <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (bus.loadEn) begin
                        count      <= CNT_W'(1);
                        overflow_q <= 1'b0;
                        ptr        <= '0;
                        epoch_q    <= '0;
                        busy_q     <= 1'b0;
                        state      <= bus.loadLast ? IDLE : LOAD;
                    end else if (bus.start && count != '0) begin
                        ptr     <= '0;
                        epoch_q <= '0;
                        busy_q  <= 1'b1;
                        state   <= SERVE;
                    end
                end

                LOAD: begin
                    if (bus.loadEn) begin
                        if (full)
                            overflow_q <= 1'b1;
                        else
                            count <= count + CNT_W'(1);
                        if (bus.loadLast)
                            state <= IDLE;
                    end
                end

                // Stage p0: memory read launched from SERVE
                SERVE: begin
                    if (bus.done) begin
                        busy_q <= 1'b0;
                        state  <= FINISH;
                    end else if (bus.requestFlag) begin
                        state <= FETCH;
                    end
                end

                // Stage p1: read word registered onto the sample outputs
                FETCH: begin
                    if (bus.done) begin
                        busy_q <= 1'b0;
                        state  <= FINISH;
                    end else begin
                        x1_p1 <= rd_p0[15:9];
                        x2_p1 <= rd_p0[8:2];
                        t_p1  <= rd_p0[1:0];
                        state <= ISSUE;
                    end
                end

                // Stage p2: strobe and pointer advance, wrapping into a new epoch
                ISSUE: begin
                    if (bus.done) begin
                        busy_q <= 1'b0;
                        state  <= FINISH;
                    end else begin
                        vld_p2 <= 1'b1;
                        if (last_ptr) begin
                            ptr     <= '0;
                            epoch_q <= sat_inc(epoch_q);
                        end else begin
                            ptr <= ptr + PTR_W'(1);
                        end
                        state <= SERVE;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.nOut      = 32'(count);
    assign bus.x1Out     = x1_p1;
    assign bus.x2Out     = x2_p1;
    assign bus.tOut      = t_p1;
    assign bus.dataReady = vld_p2;
    assign bus.epoch     = epoch_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder with a small set (DEPTH=4) and narrow epoch (EPOCH_W=3).
module tb_sample_feeder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    int tbl_x1[3] = '{5, -7, 0};
    int tbl_x2[3] = '{-3, 2, 0};
    int tbl_t [3] = '{1, -1, 1};
    int ovf_x1[4] = '{1, 3, 5, 7};
    int ovf_x2[4] = '{2, 4, 6, 8};
    int ovf_t [4] = '{1, -1, 1, -1};

    sample_feeder_if #(.EPOCH_W(3)) bus ();

    sample_feeder #(.DEPTH(4), .EPOCH_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int x1, input int x2, input int t, input logic last);
        bus.loadEn   = 1'b1;
        bus.loadX1   = 7'(x1);
        bus.loadX2   = 7'(x2);
        bus.loadT    = 2'(t);
        bus.loadLast = last;
        tick();
        bus.loadEn   = 1'b0;
        bus.loadLast = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b0;
        bus.loadEn      = 1'b0;
        bus.loadX1      = '0;
        bus.loadX2      = '0;
        bus.loadT       = '0;
        bus.loadLast    = 1'b0;
        bus.start       = 1'b0;
        bus.requestFlag = 1'b0;
        bus.done        = 1'b0;
        tick();
        tick();
        check("rst_nOut", bus.nOut, 32'd0);
        check("rst_ready", 32'(bus.dataReady), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_epoch", 32'(bus.epoch), 32'd0);
        check("rst_x1", 32'(bus.x1Out), 32'd0);
        check("rst_t", 32'(bus.tOut), 32'd0);
        rst = 1'b1;

        // Three-sample set
        for (int i = 0; i < 3; i++)
            load(tbl_x1[i], tbl_x2[i], tbl_t[i], i == 2);
        check("load3_nOut", bus.nOut, 32'd3);
        check("load3_ovf", 32'(bus.overflow), 32'd0);
        check("load3_busy", 32'(bus.busy), 32'd0);

        pulse_start();
        check("serve_busy", 32'(bus.busy), 32'd1);
        check("serve_epoch0", 32'(bus.epoch), 32'd0);
        bus.requestFlag = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("rdy_%0d", i), 32'(bus.dataReady), 32'(i % 3 == 2));
            if (i % 3 == 2) begin
                check($sformatf("x1_%0d", i), 32'(bus.x1Out), 32'(tbl_x1[(i / 3) % 3]));
                check($sformatf("x2_%0d", i), 32'(bus.x2Out), 32'(tbl_x2[(i / 3) % 3]));
                check($sformatf("t_%0d", i), 32'(bus.tOut), 32'(tbl_t[(i / 3) % 3]));
                check($sformatf("epoch_%0d", i), 32'(bus.epoch), 32'(((i / 3) + 1) / 3));
            end
        end

        // done and requestFlag together while in SERVE
        bus.done = 1'b1;
        tick();
        bus.done        = 1'b0;
        bus.requestFlag = 1'b0;
        check("fin_ready", 32'(bus.dataReady), 32'd0);
        check("fin_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fin_hold_ready", 32'(bus.dataReady), 32'd0);
        end
        check("fin_epoch", 32'(bus.epoch), 32'd1);
        check("fin_x1", 32'(bus.x1Out), 32'(5));
        check("fin_nOut", bus.nOut, 32'd3);

        // Restart from FINISH rewinds pointer and epoch
        pulse_start();
        check("restart_epoch", 32'(bus.epoch), 32'd0);
        check("restart_busy", 32'(bus.busy), 32'd1);
        bus.requestFlag = 1'b1;
        tick();
        bus.requestFlag = 1'b0;
        tick();
        tick();
        check("restart_ready", 32'(bus.dataReady), 32'd1);
        check("restart_x2", 32'(bus.x2Out), 32'(-3));

        // Reset landing while in ISSUE
        bus.requestFlag = 1'b1;
        tick();
        bus.requestFlag = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rstiss_ready", 32'(bus.dataReady), 32'd0);
        check("rstiss_nOut", bus.nOut, 32'd0);
        check("rstiss_epoch", 32'(bus.epoch), 32'd0);
        check("rstiss_busy", 32'(bus.busy), 32'd0);
        check("rstiss_x1", 32'(bus.x1Out), 32'd0);

        // start with an empty set is ignored
        pulse_start();
        check("empty_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        check("empty_ready", 32'(bus.dataReady), 32'd0);

        // start during LOAD is ignored; fifth write overflows DEPTH=4
        load(ovf_x1[0], ovf_x2[0], ovf_t[0], 1'b0);
        pulse_start();
        check("loadstart_busy", 32'(bus.busy), 32'd0);
        check("loadstart_nOut", bus.nOut, 32'd1);
        for (int i = 1; i < 4; i++)
            load(ovf_x1[i], ovf_x2[i], ovf_t[i], 1'b0);
        check("full_ovf0", 32'(bus.overflow), 32'd0);
        load(-64, 63, 1, 1'b1);
        check("ovf_nOut", bus.nOut, 32'd4);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_busy", 32'(bus.busy), 32'd0);

        pulse_start();
        bus.requestFlag = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i % 3 == 2) begin
                check($sformatf("ovf_rdy_%0d", i), 32'(bus.dataReady), 32'd1);
                check($sformatf("ovf_x1_%0d", i), 32'(bus.x1Out), 32'(ovf_x1[(i / 3) % 4]));
                check($sformatf("ovf_t_%0d", i), 32'(bus.tOut), 32'(ovf_t[(i / 3) % 4]));
                check($sformatf("ovf_ep_%0d", i), 32'(bus.epoch), 32'(((i / 3) + 1) / 4));
            end
        end
        bus.requestFlag = 1'b0;
        bus.done        = 1'b1;
        tick();
        bus.done = 1'b0;
        check("ovf_fin_busy", 32'(bus.busy), 32'd0);

        // Single extreme-valued sample: every pulse wraps, epoch saturates at 7
        load(-64, 63, -1, 1'b1);
        check("one_nOut", bus.nOut, 32'd1);
        check("one_ovf", 32'(bus.overflow), 32'd0);
        pulse_start();
        bus.requestFlag = 1'b1;
        for (int i = 0; i < 27; i++) begin
            tick();
            if (i % 3 == 2) begin
                check($sformatf("sat_rdy_%0d", i), 32'(bus.dataReady), 32'd1);
                check($sformatf("sat_x1_%0d", i), 32'(bus.x1Out), 32'(-64));
                check($sformatf("sat_x2_%0d", i), 32'(bus.x2Out), 32'(63));
                check($sformatf("sat_t_%0d", i), 32'(bus.tOut), 32'(-1));
                check($sformatf("sat_ep_%0d", i), 32'(bus.epoch),
                      32'(((i / 3) + 1) > 7 ? 7 : (i / 3) + 1));
            end
        end
        bus.requestFlag = 1'b0;
        bus.done        = 1'b1;
        tick();
        bus.done = 1'b0;
        check("sat_fin_busy", 32'(bus.busy), 32'd0);
        check("sat_fin_epoch", 32'(bus.epoch), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
